// File: rtl/roi_insert_pkg.sv
// Shared types and helpers for the ROI frame inserter: FSM state encoding,
// default frame geometry and the origin clamp used when a frame is started.
package roi_insert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_FRAME_ROWS = 20;
    localparam int DEF_FRAME_COLS = 20;
    localparam int COL_W = $clog2(DEF_FRAME_COLS);
    localparam int ROW_W = $clog2(DEF_FRAME_ROWS);

    // Clamp arithmetic is done with headroom beyond either coordinate width.
    localparam int ORIGIN_W = ((COL_W > ROW_W) ? COL_W : ROW_W) + 11;

    function automatic logic [ORIGIN_W-1:0] clamp_origin(
        input logic [ORIGIN_W-1:0] req,
        input logic [ORIGIN_W-1:0] limit
    );
        if (req > limit) begin
            return limit;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Raster-order row/column generator with advance enable, synchronous clear
// and a flag marking the final pixel of the frame.
module frame_pos_counter #(
    parameter int ROWS = 20,
    parameter int COLS = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    advance,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    last_pixel
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;

    // Position register: column wraps into a row increment, row wraps to top.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row_r <= '0;
            col_r <= '0;
        end else if (advance) begin
            if (col_r == LAST_COL) begin
                col_r <= '0;
                row_r <= (row_r == LAST_ROW) ? '0 : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    assign row        = row_r;
    assign col        = col_r;
    assign last_pixel = (row_r == LAST_ROW) && (col_r == LAST_COL);

endmodule

// File: rtl/roi_frame_inserter.sv
// Rebuilds a full frame from a cropped ROI stream: ROI pixels are placed at a
// latched origin and every other position is filled with a background value.
module roi_frame_inserter
    import roi_insert_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int FRAME_ROWS      = DEF_FRAME_ROWS,
    parameter int FRAME_COLS      = DEF_FRAME_COLS,
    parameter int ROI_ROWS        = 10,
    parameter int ROI_COLS        = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    input  logic [$clog2(FRAME_COLS)-1:0] roi_x0,
    input  logic [$clog2(FRAME_ROWS)-1:0] roi_y0,
    input  logic [PIXEL_BIT_WIDTH-1:0]    fill_value,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]    s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [$clog2(FRAME_COLS)-1:0] cnt_col,
    output logic [$clog2(FRAME_ROWS)-1:0] cnt_row
);
    localparam int CW = $clog2(FRAME_COLS);
    localparam int RW = $clog2(FRAME_ROWS);
    localparam logic [CW:0]   ROI_W    = (CW + 1)'(ROI_COLS);
    localparam logic [RW:0]   ROI_H    = (RW + 1)'(ROI_ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(FRAME_COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(FRAME_ROWS - 1);

    state_t state_r;
    state_t state_next;

    logic [CW-1:0]              x0_r;
    logic [RW-1:0]              y0_r;
    logic [PIXEL_BIT_WIDTH-1:0] fill_r;
    logic                       loaded_all_r;

    logic                       tvalid_r;
    logic [PIXEL_BIT_WIDTH-1:0] tdata_r;
    logic                       tuser_r;
    logic                       tlast_r;
    logic [CW-1:0]              cnt_col_r;
    logic [RW-1:0]              cnt_row_r;

    logic [RW-1:0]              gen_row;
    logic [CW-1:0]              gen_col;
    logic                       gen_last;

    logic                       start_s;
    logic                       load_ok_s;
    logic                       gen_active_s;
    logic                       in_win_s;
    logic                       load_s;
    logic                       last_hs_s;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_s;
    logic [RW:0]                row_ext_s;
    logic [CW:0]                col_ext_s;
    logic [RW:0]                y0_ext_s;
    logic [CW:0]                x0_ext_s;

    frame_pos_counter #(
        .ROWS (FRAME_ROWS),
        .COLS (FRAME_COLS)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_s),
        .advance    (load_s),
        .row        (gen_row),
        .col        (gen_col),
        .last_pixel (gen_last)
    );

    assign start_s      = (state_r == IDLE) && ap_start;
    assign load_ok_s    = !tvalid_r || m_axis_tready;
    assign gen_active_s = (state_r == RUN) && !loaded_all_r;
    assign last_hs_s    = tvalid_r && m_axis_tready && tlast_r && (cnt_row_r == LAST_ROW);

    // Bounds are one bit wider than the coordinates so origin+size cannot wrap.
    assign row_ext_s = {1'b0, gen_row};
    assign col_ext_s = {1'b0, gen_col};
    assign y0_ext_s  = {1'b0, y0_r};
    assign x0_ext_s  = {1'b0, x0_r};

    // Window test and choice of what, if anything, enters the output register.
    always_comb begin
        in_win_s = (row_ext_s >= y0_ext_s) && (row_ext_s < (y0_ext_s + ROI_H)) &&
                   (col_ext_s >= x0_ext_s) && (col_ext_s < (x0_ext_s + ROI_W));
        load_s   = 1'b0;
        pixel_s  = fill_r;
        if (gen_active_s && load_ok_s) begin
            if (in_win_s) begin
                load_s  = s_axis_tvalid;
                pixel_s = s_axis_tdata;
            end else begin
                load_s  = 1'b1;
                pixel_s = fill_r;
            end
        end else begin
            load_s  = 1'b0;
            pixel_s = fill_r;
        end
    end

    assign s_axis_tready = gen_active_s && in_win_s && load_ok_s;

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_hs_s) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Frame configuration, captured once per frame at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_r   <= '0;
            y0_r   <= '0;
            fill_r <= '0;
        end else if (start_s) begin
            x0_r   <= CW'(clamp_origin(ORIGIN_W'(roi_x0), ORIGIN_W'(FRAME_COLS - ROI_COLS)));
            y0_r   <= RW'(clamp_origin(ORIGIN_W'(roi_y0), ORIGIN_W'(FRAME_ROWS - ROI_ROWS)));
            fill_r <= fill_value;
        end
    end

    // Stops generation once the final pixel has entered the output register.
    always_ff @(posedge clk) begin
        if (reset || start_s) begin
            loaded_all_r <= 1'b0;
        end else if (load_s && gen_last) begin
            loaded_all_r <= 1'b1;
        end
    end

    // Output register stage; metadata travels with each loaded pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid_r  <= 1'b0;
            tdata_r   <= '0;
            tuser_r   <= 1'b0;
            tlast_r   <= 1'b0;
            cnt_col_r <= '0;
            cnt_row_r <= '0;
        end else if (load_s) begin
            tvalid_r  <= 1'b1;
            tdata_r   <= pixel_s;
            tuser_r   <= (gen_row == '0) && (gen_col == '0);
            tlast_r   <= (gen_col == LAST_COL);
            cnt_col_r <= gen_col;
            cnt_row_r <= gen_row;
        end else if (m_axis_tready) begin
            tvalid_r  <= 1'b0;
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tuser  = tuser_r;
    assign m_axis_tlast  = tlast_r;
    assign cnt_col       = cnt_col_r;
    assign cnt_row       = cnt_row_r;
    assign ap_done       = (state_r == DONE);
    assign ap_idle       = (state_r == IDLE);

endmodule

// File: doc/roi_frame_inserter.md
Name: roi_frame_inserter

Overview:
Inverse of the crop stage. Takes a ROI_ROWS x ROI_COLS pixel stream on AXI-Stream and emits a full FRAME_ROWS x FRAME_COLS frame, also on AXI-Stream. The ROI is placed at (roi_x0, roi_y0), and every other pixel is set to fill_value. Used to rebuild full-size frames for display or readback after cropped processing. Output carries row/column position and start-of-frame/end-of-row markers.

Parameters:
PIXEL_BIT_WIDTH, 10, pixel data width
FRAME_ROWS, 20, output frame height
FRAME_COLS, 20, output frame width
ROI_ROWS, 10, input ROI height; must be <= FRAME_ROWS
ROI_COLS, 10, input ROI width; must be <= FRAME_COLS

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
ap_start  in  1  start one frame; sampled only in IDLE
ap_done  out  1  one-cycle pulse when the frame is complete
ap_idle  out  1  high in IDLE
roi_x0  in  $clog2(FRAME_COLS)  ROI left column; latched at start
roi_y0  in  $clog2(FRAME_ROWS)  ROI top row; latched at start
fill_value  in  PIXEL_BIT_WIDTH  background pixel value; latched at start
s_axis_tvalid  in  1  ROI pixel valid
s_axis_tready  out  1  ROI pixel accepted
s_axis_tdata  in  PIXEL_BIT_WIDTH  ROI pixel, raster order
m_axis_tvalid  out  1  frame pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  PIXEL_BIT_WIDTH  frame pixel
m_axis_tuser  out  1  high on pixel (0,0)
m_axis_tlast  out  1  high on the last column of each row
cnt_col  out  $clog2(FRAME_COLS)  column of the pixel currently on m_axis
cnt_row  out  $clog2(FRAME_ROWS)  row of the pixel currently on m_axis

Behaviour:
- Reset values: all outputs 0 except ap_idle=1; state IDLE; position counters 0.
- FSM states:
  - IDLE -> RUN on ap_start. On this transition, latch x0 = min(roi_x0, FRAME_COLS-ROI_COLS), y0 = min(roi_y0, FRAME_ROWS-ROI_ROWS), and fill_value.
  - RUN -> DONE on the m_axis handshake of pixel (FRAME_ROWS-1, FRAME_COLS-1).
  - DONE -> IDLE unconditionally after 1 cycle. ap_done=1 only in DONE.
- ap_start is ignored outside IDLE. Input changes after the latch have no effect on the current frame.
- Generation position (gr, gc) advances raster order:
  - gc wraps FRAME_COLS-1 -> 0, then gr increments.
  - Position advances once per pixel loaded into the output register.
- Output register: a single registered stage. load_ok = !m_axis_tvalid || m_axis_tready.
- In-window test: gr in [y0, y0+ROI_ROWS) and gc in [x0, x0+ROI_COLS).
- When in-window:
  - s_axis_tready = RUN && load_ok.
  - On s_axis handshake, load s_axis_tdata.
  - If s_axis_tvalid=0, m_axis_tvalid drops once the current pixel drains.
  - Position holds until s_axis_tvalid returns.
- When out of window:
  - s_axis_tready = 0.
  - In RUN with load_ok, load fill_value; no dependence on s_axis.
- Loaded pixels carry their metadata: tuser=(gr==0 && gc==0), tlast=(gc==FRAME_COLS-1), cnt_row=gr, cnt_col=gc.
- Latency: 1 cycle from load to m_axis_tvalid. Sustains 1 pixel/cycle with m_axis_tready=1.
- Backpressure: while m_axis_tvalid && !m_axis_tready, all m_axis outputs are held stable.
- After the last pixel loads:
  - No further loads; s_axis_tready=0 until the next frame.
  - Extra ROI pixels remain unconsumed upstream.
- Reset mid-frame: next cycle returns all outputs to reset values and discards the output register. The next frame restarts at (0,0).
- Arithmetic: window bounds are computed at width $clog2(FRAME)+1 to avoid overflow.

Decomposition:
- Package roi_insert_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparams COL_W=$clog2(FRAME_COLS), ROW_W=$clog2(FRAME_ROWS);
  - clamp function.
- One natural sub-module, frame_pos_counter: raster row/col counter with enable, wrap, and last-pixel flag.

Test Plan (FRAME 6 rows x 8 cols, ROI 3x4):
1. x0=2, y0=1, fill=0, ROI data 1..12, m_tready=1 -> 48 beats. (1,2)=1, (1,5)=4, (3,5)=12, all others 0. tuser on beat 0, tlast on beats 7,15,...,47. ap_done pulses once, the cycle after beat 47.
2. Same stimulus, m_tready pattern 1,0,1,0... -> identical 48-value sequence, no drop or duplicate. Outputs stable during stalls.
3. s_tvalid low for 5 cycles mid-ROI row -> m_tvalid gaps only at in-window positions. Fill pixels before (1,2) are emitted without waiting.
4. roi_x0=7, roi_y0=5 -> ROI clamped to x0=4, y0=3. Value 1 at (3,4), 12 at (5,7).
5. Reset after 20 beats -> next cycle m_tvalid=0, ap_idle=1. New ap_start gives a full 48-beat frame with tuser on beat 0.
6. ap_start pulsed and roi_x0 changed to 0 during RUN -> no effect. Frame matches scenario 1; a single ap_done.
